peregrine_pif_initiator: RTL and testbench

PEREGRINE_PIF_INITIATOR -- requirements
Module: peregrine_pif_initiator

---
 rtl/peregrine_pif_pkg.sv | 34 +++
 rtl/peregrine_pif_timer.sv | 29 ++
 rtl/peregrine_pif_initiator.sv | 182 ++++++++++++++++++
 tb/tb_peregrine_pif_initiator.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peregrine_pif_pkg.sv
// Shared PIF encodings, command opcodes and initiator FSM states.
package peregrine_pif_pkg;

    localparam logic [3:0] PifOpRead      = 4'b0000;
    localparam logic [3:0] PifOpWrite     = 4'b1000;
    localparam logic [3:0] PifOpBlockRead = 4'b0001;
    localparam logic [1:0] PifBlock4      = 2'b01;

    localparam logic [6:0] PifStatOk      = 7'd0;
    localparam logic [6:0] PifStatAddrErr = 7'd1;

    typedef enum logic [1:0] {
        OpRead      = 2'd0,
        OpWrite     = 2'd1,
        OpBlockRead = 2'd2,
        OpRsvd      = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StErr
    } state_e;

    function automatic logic [7:0] req_cntl(cmd_op_e op);
        case (op)
            OpWrite:     return {PifOpWrite, 1'b0, 2'b00, 1'b1};
            OpBlockRead: return {PifOpBlockRead, 1'b0, PifBlock4, 1'b1};
            default:     return {PifOpRead, 1'b0, 2'b00, 1'b1};
        endcase
    endfunction

endpackage

// File: rtl/peregrine_pif_timer.sv
// Response timeout counter: counts enabled cycles, saturates and flags at TIMEOUT.
module peregrine_pif_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] Limit = W'(TIMEOUT);

    logic [W-1:0] cnt_q;

    assign expired = (cnt_q == Limit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/peregrine_pif_initiator.sv
// Single-outstanding PIF initiator: command in, PIF request out, read beats back to consumer.
module peregrine_pif_initiator
    import peregrine_pif_pkg::*;
#(
    parameter logic [1:0]  PRIORITY = 2'h0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_error,
    output logic [2:0]  err_flags,
    output logic        POReqValid,
    input  logic        PIReqRdy,
    output logic [7:0]  POReqCntl,
    output logic [31:0] POReqAdrs,
    output logic [31:0] POReqData,
    output logic [3:0]  POReqDataBE,
    output logic [5:0]  POReqId,
    output logic [1:0]  POReqPriority,
    input  logic        PIRespValid,
    output logic        PORespRdy,
    input  logic [7:0]  PIRespCntl,
    input  logic [31:0] PIRespData,
    input  logic [5:0]  PIRespId
);

    state_e      state_q, state_d;
    logic        active_q;
    logic [7:0]  cntl_q;
    logic [31:0] addr_q, data_q;
    logic [3:0]  be_q;
    logic        block_q, write_q;
    logic [5:0]  id_q, issued_id_q;
    logic [2:0]  beat_q, beat_next, beats_exp;
    logic [2:0]  err_q;

    cmd_op_e op_in;
    logic    cmd_fire, req_fire, rsp_fire, stray_rsp;
    logic    rsp_is_err, count_hit, wait_done, timer_expired;

    assign op_in      = cmd_op_e'(cmd_op);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign req_fire   = (state_q == StReq) && PIReqRdy;
    assign rsp_fire   = (state_q == StWait) && PIRespValid && rsp_ready;
    assign stray_rsp  = (state_q != StWait) && PIRespValid && PORespRdy;
    assign rsp_is_err = (PIRespCntl[7:1] != PifStatOk);
    assign beats_exp  = block_q ? 3'd4 : 3'd1;
    assign beat_next  = beat_q + 3'd1;
    assign count_hit  = (beat_next == beats_exp);
    // An error-status beat or a count overrun also closes the transaction so it cannot hang.
    assign wait_done  = rsp_fire && (PIRespCntl[0] || rsp_is_err || count_hit);

    peregrine_pif_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (RESETn),
        .enable  ((state_q == StWait) && !rsp_fire),
        .clear   ((state_q != StWait) || rsp_fire),
        .expired (timer_expired)
    );

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_fire) state_d = (op_in == OpRsvd) ? StErr : StReq;
            StReq:  if (PIReqRdy) state_d = write_q ? StIdle : StWait;
            StWait: begin
                if (wait_done) begin
                    state_d = StIdle;
                end else if (timer_expired) begin
                    state_d = StErr;
                end
            end
            StErr:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        PORespRdy  = 1'b0;
        POReqValid = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        rsp_error  = 1'b0;
        rsp_last   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = active_q;
                PORespRdy = active_q;
            end
            StReq: begin
                POReqValid = 1'b1;
                PORespRdy  = 1'b1;
            end
            StWait: begin
                PORespRdy = rsp_ready;
                rsp_valid = PIRespValid;
                rsp_data  = PIRespData;
                rsp_error = rsp_is_err;
                rsp_last  = PIRespCntl[0];
            end
            StErr: begin
                rsp_valid = 1'b1;
                rsp_error = 1'b1;
                rsp_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            active_q    <= 1'b0;
            cntl_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            block_q     <= 1'b0;
            write_q     <= 1'b0;
            id_q        <= '0;
            issued_id_q <= '0;
            beat_q      <= '0;
            err_q       <= '0;
        end else begin
            active_q <= 1'b1;
            if (cmd_fire && (op_in != OpRsvd)) begin
                cntl_q  <= req_cntl(op_in);
                addr_q  <= cmd_addr;
                data_q  <= cmd_data;
                be_q    <= cmd_be;
                block_q <= (op_in == OpBlockRead);
                write_q <= (op_in == OpWrite);
                beat_q  <= '0;
            end
            if (req_fire) begin
                id_q        <= id_q + 6'd1;
                issued_id_q <= id_q;
            end
            if (rsp_fire) begin
                beat_q <= beat_next;
                if (PIRespId != issued_id_q) err_q[0] <= 1'b1;
                if (!rsp_is_err && (PIRespCntl[0] != count_hit)) err_q[1] <= 1'b1;
            end
            if (stray_rsp) begin
                if (rsp_is_err) begin
                    err_q[2] <= 1'b1;
                end else begin
                    err_q[1] <= 1'b1;
                end
            end
        end
    end

    assign err_flags     = err_q;
    assign POReqCntl     = cntl_q;
    assign POReqAdrs     = addr_q;
    assign POReqData     = data_q;
    assign POReqDataBE   = be_q;
    assign POReqId       = id_q;
    assign POReqPriority = PRIORITY;

endmodule

// File: tb/tb_peregrine_pif_initiator.sv
// Directed bench for peregrine_pif_initiator with a response scoreboard and negedge monitor.
module tb_peregrine_pif_initiator;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_data;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_ready, rsp_last, rsp_error;
    logic [31:0] rsp_data;
    logic [2:0]  err_flags;
    logic        POReqValid, PIReqRdy;
    logic [7:0]  POReqCntl;
    logic [31:0] POReqAdrs, POReqData;
    logic [3:0]  POReqDataBE;
    logic [5:0]  POReqId;
    logic [1:0]  POReqPriority;
    logic        PIRespValid, PORespRdy;
    logic [7:0]  PIRespCntl;
    logic [31:0] PIRespData;
    logic [5:0]  PIRespId;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        last;
    } beat_t;

    beat_t      sb[$];
    beat_t      mon_e;
    int         tests = 0;
    int         fails = 0;
    logic [5:0] exp_id = 6'd0;

    peregrine_pif_initiator #(
        .PRIORITY (2'h2),
        .TIMEOUT  (16)
    ) dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .cmd_be        (cmd_be),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .rsp_error     (rsp_error),
        .err_flags     (err_flags),
        .POReqValid    (POReqValid),
        .PIReqRdy      (PIReqRdy),
        .POReqCntl     (POReqCntl),
        .POReqAdrs     (POReqAdrs),
        .POReqData     (POReqData),
        .POReqDataBE   (POReqDataBE),
        .POReqId       (POReqId),
        .POReqPriority (POReqPriority),
        .PIRespValid   (PIRespValid),
        .PORespRdy     (PORespRdy),
        .PIRespCntl    (PIRespCntl),
        .PIRespData    (PIRespData),
        .PIRespId      (PIRespId)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response transfer must match the oldest expected beat.
    always @(negedge CLK) begin
        if (RESETn === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got data 0x%0h, expected no beat", rsp_data);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_data", rsp_data, mon_e.data);
                check("rsp_error", 32'(rsp_error), 32'(mon_e.err));
                check("rsp_last", 32'(rsp_last), 32'(mon_e.last));
            end
        end
    end

    task automatic expect_beat(input logic [31:0] data, input logic err, input logic last);
        beat_t b;
        b.data = data;
        b.err  = err;
        b.last = last;
        sb.push_back(b);
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
        bit ok = 1'b0;
        int n  = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_be    = be;
        while (!ok && n < 20) begin
            @(negedge CLK);
            ok = (cmd_ready === 1'b1);
            @(posedge CLK);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(ok), 32'd1);
    endtask

    task automatic accept_req(input logic [7:0] cntl, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] be, input int stall);
        for (int i = 0; i < stall; i++) begin
            @(negedge CLK);
            check("req_valid_stall", 32'(POReqValid), 32'd1);
            check("req_cntl_stable", 32'(POReqCntl), 32'(cntl));
            check("req_addr_stable", POReqAdrs, addr);
            check("req_data_stable", POReqData, data);
            check("req_be_stable", 32'(POReqDataBE), 32'(be));
            @(posedge CLK);
            #1;
        end
        PIReqRdy = 1'b1;
        @(negedge CLK);
        check("req_valid", 32'(POReqValid), 32'd1);
        check("req_cntl", 32'(POReqCntl), 32'(cntl));
        check("req_addr", POReqAdrs, addr);
        check("req_data", POReqData, data);
        check("req_be", 32'(POReqDataBE), 32'(be));
        check("req_id", 32'(POReqId), 32'(exp_id));
        check("req_priority", 32'(POReqPriority), 32'h2);
        @(posedge CLK);
        #1;
        PIReqRdy = 1'b0;
        exp_id   = exp_id + 6'd1;
    endtask

    task automatic send_beat(input logic [31:0] data, input logic [6:0] status, input logic last,
                             input logic [5:0] id, input bit hold);
        bit ok = 1'b0;
        int n  = 0;
        expect_beat(data, status != 7'd0, last);
        PIRespValid = 1'b1;
        PIRespCntl  = {status, last};
        PIRespData  = data;
        PIRespId    = id;
        if (hold) begin
            rsp_ready = 1'b0;
            @(negedge CLK);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_resp_rdy", 32'(PORespRdy), 32'd0);
            @(posedge CLK);
            #1;
            rsp_ready = 1'b1;
        end
        while (!ok && n < 20) begin
            @(negedge CLK);
            ok = (PORespRdy === 1'b1);
            @(posedge CLK);
            #1;
            n++;
        end
        check("beat_taken", 32'(ok), 32'd1);
        PIRespValid = 1'b0;
        PIRespCntl  = 8'h00;
    endtask

    initial begin
        int first;
        RESETn      = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_addr    = '0;
        cmd_data    = '0;
        cmd_be      = '0;
        rsp_ready   = 1'b1;
        PIReqRdy    = 1'b0;
        PIRespValid = 1'b0;
        PIRespCntl  = '0;
        PIRespData  = '0;
        PIRespId    = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_resp_rdy", 32'(PORespRdy), 32'd0);
        check("rst_req_valid", 32'(POReqValid), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err_flags", 32'(err_flags), 32'd0);
        check("rst_id", 32'(POReqId), 32'd0);
        check("rst_cntl", 32'(POReqCntl), 32'd0);
        check("rst_addr", POReqAdrs, 32'd0);
        RESETn = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_resp_rdy", 32'(PORespRdy), 32'd1);

        // Single READ, OK response.
        issue_cmd(2'd0, 32'hC000_0010, 32'h0, 4'hF);
        accept_req(8'h01, 32'hC000_0010, 32'h0, 4'hF, 0);
        check("id_after_read", 32'(POReqId), 32'd1);
        send_beat(32'h1234_5678, 7'd0, 1'b1, 6'd0, 1'b0);
        check("zero_bubble_read", 32'(cmd_ready), 32'd1);

        // BLOCK_READ with consumer back-pressure on each beat.
        issue_cmd(2'd2, 32'hC000_0000, 32'h0, 4'hF);
        accept_req(8'h13, 32'hC000_0000, 32'h0, 4'hF, 0);
        for (int i = 0; i < 4; i++) begin
            send_beat(32'hA000_0000 + 32'(i), 7'd0, i == 3, 6'd1, 1'b1);
        end
        check("zero_bubble_block", 32'(cmd_ready), 32'd1);
        check("flags_after_block", 32'(err_flags), 32'd0);

        // WRITE stalled three cycles.
        issue_cmd(2'd1, 32'h1000_0020, 32'hDEAD_BEEF, 4'hA);
        accept_req(8'h81, 32'h1000_0020, 32'hDEAD_BEEF, 4'hA, 3);
        check("write_cmd_ready_next", 32'(cmd_ready), 32'd1);
        check("id_after_write", 32'(POReqId), 32'd3);

        // READ with address-error response.
        issue_cmd(2'd0, 32'h0000_0000, 32'h0, 4'hF);
        accept_req(8'h01, 32'h0000_0000, 32'h0, 4'hF, 0);
        send_beat(32'h0000_0000, 7'd1, 1'b1, 6'd3, 1'b0);
        check("flags_after_addr_err", 32'(err_flags), 32'd0);

        // Reserved op: error beat held until accepted, no PIF request.
        rsp_ready = 1'b0;
        expect_beat(32'h0, 1'b1, 1'b1);
        issue_cmd(2'd3, 32'h5555_0000, 32'h0, 4'hF);
        @(negedge CLK);
        check("rsvd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsvd_no_req", 32'(POReqValid), 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rsvd_rsp_hold", 32'(rsp_valid), 32'd1);
        @(posedge CLK);
        #1;
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("rsvd_back_idle", 32'(cmd_ready), 32'd1);
        check("rsvd_id_unchanged", 32'(POReqId), 32'd4);

        // Response ID mismatch still forwards data.
        issue_cmd(2'd0, 32'hC000_0040, 32'h0, 4'hF);
        accept_req(8'h01, 32'hC000_0040, 32'h0, 4'hF, 0);
        send_beat(32'hCAFE_0001, 7'd0, 1'b1, 6'd5, 1'b0);
        check("flags_id_mismatch", 32'(err_flags), 32'b001);

        // BLOCK_READ terminated early by last on beat 2.
        issue_cmd(2'd2, 32'hC000_0080, 32'h0, 4'hF);
        accept_req(8'h13, 32'hC000_0080, 32'h0, 4'hF, 0);
        send_beat(32'hB000_0000, 7'd0, 1'b0, 6'd5, 1'b0);
        send_beat(32'hB000_0001, 7'd0, 1'b1, 6'd5, 1'b0);
        check("flags_early_last", 32'(err_flags), 32'b011);
        check("early_last_idle", 32'(cmd_ready), 32'd1);

        // Posted WRITE followed by a stray error response.
        issue_cmd(2'd1, 32'h1000_0100, 32'h0000_0001, 4'h1);
        accept_req(8'h81, 32'h1000_0100, 32'h0000_0001, 4'h1, 0);
        PIRespValid = 1'b1;
        PIRespCntl  = {7'd1, 1'b1};
        @(posedge CLK);
        #1;
        PIRespValid = 1'b0;
        PIRespCntl  = 8'h00;
        check("flags_stray_err", 32'(err_flags), 32'b111);

        // READ with no response: synthetic timeout beat.
        issue_cmd(2'd0, 32'hC000_0100, 32'h0, 4'hF);
        accept_req(8'h01, 32'hC000_0100, 32'h0, 4'hF, 0);
        expect_beat(32'h0, 1'b1, 1'b1);
        first = 0;
        for (int n = 1; n <= 30 && first == 0; n++) begin
            @(negedge CLK);
            if (rsp_valid === 1'b1) first = n;
        end
        check("timeout_window", 32'(first >= 16 && first <= 18), 32'd1);
        @(posedge CLK);
        #1;
        check("timeout_back_idle", 32'(cmd_ready), 32'd1);

        // Reset while waiting for a response abandons the transaction.
        issue_cmd(2'd0, 32'hC000_0200, 32'h0, 4'hF);
        accept_req(8'h01, 32'hC000_0200, 32'h0, 4'hF, 0);
        repeat (3) @(posedge CLK);
        #1;
        RESETn = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_id", 32'(POReqId), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst_flags", 32'(err_flags), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        RESETn = 1'b1;
        exp_id = 6'd0;
        @(posedge CLK);
        #1;
        check("midrst_release_ready", 32'(cmd_ready), 32'd1);
        issue_cmd(2'd0, 32'hC000_0300, 32'h0, 4'hF);
        accept_req(8'h01, 32'hC000_0300, 32'h0, 4'hF, 0);
        send_beat(32'h0BAD_F00D, 7'd0, 1'b1, 6'd0, 1'b0);

        // Walk the ID through 63 -> 0.
        for (int i = 0; i < 63; i++) begin
            issue_cmd(2'd1, 32'h2000_0000 + 32'(i * 4), 32'(i), 4'hF);
            accept_req(8'h81, 32'h2000_0000 + 32'(i * 4), 32'(i), 4'hF, 0);
        end
        check("id_wrap", 32'(POReqId), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("flags_final", 32'(err_flags), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
